// File: rtl/regfile_wr_demux.sv
// rtl/regfile_wr_demux.sv - queued 1-to-32 register-file write demux, x0 hardwired to zero
// Optional sticky x0-write flag output enabled by macro RF_X0_WRITE_FLAG_EN.
module regfile_wr_demux #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_wr_valid,
  output logic               o_wr_ready,
  input  logic [4:0]         i_wr_addr,
  input  logic [XLEN-1:0]    i_wr_data,
  input  logic               i_wr_hold,
  output logic [31:0]        o_we_onehot,
  output logic [32*XLEN-1:0] o_regs_flat,
`ifdef RF_X0_WRITE_FLAG_EN
  output logic               o_x0_wr_flag,
`endif
  output logic               o_busy
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  logic [XLEN-1:0] r_regs [31:1];
  logic [4:0]      r_q_addr [2];
  logic [XLEN-1:0] r_q_data [2];
  logic            r_head;
  logic            r_tail;
  logic [1:0]      r_count;
  logic [31:0]     r_we_onehot;

  logic            w_push;
  logic            w_pop;
  logic [4:0]      w_head_addr;
  logic [XLEN-1:0] w_head_data;
  logic [31:0]     w_dec;

  assign o_wr_ready  = (r_count < FULL);
  assign o_busy      = (r_count != 2'd0);
  assign w_push      = i_wr_valid & o_wr_ready;
  assign w_pop       = o_busy & ~i_wr_hold;
  assign w_head_addr = r_q_addr[r_head];
  assign w_head_data = r_q_data[r_head];
  assign w_dec       = 32'd1 << w_head_addr;
  assign o_we_onehot = r_we_onehot;

  // Queue payload needs no reset: count gates every read of it.
  always_ff @(posedge i_clk) begin
    if (w_push && !i_rst) begin
      r_q_addr[r_tail] <= i_wr_addr;
      r_q_data[r_tail] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_head      <= 1'b0;
      r_tail      <= 1'b0;
      r_count     <= 2'd0;
      r_we_onehot <= 32'd0;
    end else begin
      if (w_push) r_tail <= ~r_tail;
      if (w_pop)  r_head <= ~r_head;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
      r_we_onehot <= w_pop ? {w_dec[31:1], 1'b0} : 32'd0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 1; i < 32; i++) r_regs[i] <= '0;
    end else if (w_pop && (w_head_addr != 5'd0)) begin
      r_regs[w_head_addr] <= w_head_data;
    end
  end

  assign o_regs_flat[XLEN-1:0] = '0;
  for (genvar g = 1; g < 32; g++) begin : g_flat
    assign o_regs_flat[g*XLEN +: XLEN] = r_regs[g];
  end

`ifdef RF_X0_WRITE_FLAG_EN
  logic r_x0_flag;
  always_ff @(posedge i_clk) begin
    if (i_rst)                                   r_x0_flag <= 1'b0;
    else if (w_pop && (w_head_addr == 5'd0))     r_x0_flag <= 1'b1;
  end
  assign o_x0_wr_flag = r_x0_flag;
`endif

endmodule

// File: tb/tb_regfile_wr_demux.sv
// tb/tb_regfile_wr_demux.sv - random + directed bench with a queue-based reference model
module tb_regfile_wr_demux;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         wr_valid = 1'b0;
  logic         wr_ready;
  logic [4:0]   wr_addr = 5'd0;
  logic [31:0]  wr_data = 32'd0;
  logic         wr_hold = 1'b0;
  logic [31:0]  we_onehot;
  logic [1023:0] regs_flat;
  logic         busy;
`ifdef RF_X0_WRITE_FLAG_EN
  logic         x0_wr_flag;
`endif

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  regfile_wr_demux #(.XLEN(32), .DEPTH(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_wr_valid(wr_valid), .o_wr_ready(wr_ready),
    .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_wr_hold(wr_hold),
    .o_we_onehot(we_onehot), .o_regs_flat(regs_flat),
`ifdef RF_X0_WRITE_FLAG_EN
    .o_x0_wr_flag(x0_wr_flag),
`endif
    .o_busy(busy)
  );

  typedef struct { logic [4:0] a; logic [31:0] d; } ent_t;
  ent_t        mq[$];
  logic [31:0] m_regs [32];
  logic [31:0] m_onehot = 32'd0;
  bit          m_flag = 1'b0;

  initial for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;

  // Reference model: a 2-deep FIFO of requests, one drained per unheld cycle.
  always @(posedge clk) begin
    int   sz;
    bit   push, pop;
    ent_t e;
    if (rst) begin
      mq.delete();
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_onehot = 32'd0;
      m_flag   = 1'b0;
    end else begin
      sz = mq.size();
      push = wr_valid && (sz < 2);
      pop  = (sz > 0) && !wr_hold;
      m_onehot = 32'd0;
      if (pop) begin
        e = mq.pop_front();
        if (e.a != 5'd0) begin
          m_regs[e.a] = e.d;
          m_onehot = 32'd1 << e.a;
        end else begin
          m_flag = 1'b1;
        end
      end
      if (push) mq.push_back('{wr_addr, wr_data});
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int bad;
      checks++;
      if (wr_ready !== (mq.size() < 2)) begin
        errors++; $display("FAIL model_ready act=%0b exp=%0b t=%0t", wr_ready, mq.size() < 2, $time);
      end
      checks++;
      if (busy !== (mq.size() != 0)) begin
        errors++; $display("FAIL model_busy act=%0b exp=%0b t=%0t", busy, mq.size() != 0, $time);
      end
      checks++;
      if (we_onehot !== m_onehot) begin
        errors++; $display("FAIL model_onehot act=%h exp=%h t=%0t", we_onehot, m_onehot, $time);
      end
      bad = -1;
      for (int i = 31; i >= 0; i--) if (regs_flat[i*32 +: 32] !== m_regs[i]) bad = i;
      checks++;
      if (bad >= 0) begin
        errors++; $display("FAIL model_reg%0d act=%h exp=%h t=%0t", bad, regs_flat[bad*32 +: 32], m_regs[bad], $time);
      end
`ifdef RF_X0_WRITE_FLAG_EN
      checks++;
      if (x0_wr_flag !== m_flag) begin
        errors++; $display("FAIL model_x0flag act=%0b exp=%0b t=%0t", x0_wr_flag, m_flag, $time);
      end
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++; $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rg(input int i);
    return regs_flat[i*32 +: 32];
  endfunction

  initial begin
    @(negedge clk);
    cyc(); cyc();
    rst = 1'b0;
    chk_en = 1'b1;
    lit("reset_ready", {31'd0, wr_ready}, 32'd1);
    lit("reset_busy", {31'd0, busy}, 32'd0);
    lit("reset_onehot", we_onehot, 32'd0);

    for (int n = 0; n < 400; n++) begin
      if (!(wr_valid && !wr_ready) || rst) begin
        wr_valid = ($urandom_range(0, 3) != 0);
        wr_addr  = 5'($urandom_range(0, 31));
        wr_data  = $urandom;
      end
      wr_hold = ($urandom_range(0, 3) == 0);
      rst     = ($urandom_range(0, 60) == 0);
      cyc();
    end

    wr_valid = 1'b0; wr_hold = 1'b0; rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    lit("rst2_bank_zero", {31'd0, |regs_flat}, 32'd0);
    lit("rst2_onehot", we_onehot, 32'd0);
    lit("rst2_ready", {31'd0, wr_ready}, 32'd1);
    lit("rst2_busy", {31'd0, busy}, 32'd0);

    wr_valid = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    cyc();
    wr_valid = 1'b0;
    lit("single_not_yet", rg(5), 32'd0);
    lit("single_busy", {31'd0, busy}, 32'd1);
    cyc();
    lit("single_reg5", rg(5), 32'hDEADBEEF);
    lit("single_onehot", we_onehot, 32'h0000_0020);
    cyc();
    lit("single_onehot_off", we_onehot, 32'd0);

    wr_hold = 1'b1;
    wr_valid = 1'b1; wr_addr = 5'd1; wr_data = 32'h11;
    cyc();
    wr_addr = 5'd2; wr_data = 32'h22;
    cyc();
    lit("bp_ready_low", {31'd0, wr_ready}, 32'd0);
    wr_addr = 5'd3; wr_data = 32'h33;
    cyc();
    lit("bp_stalled", {31'd0, wr_ready}, 32'd0);
    lit("bp_no_commit", rg(1), 32'd0);
    wr_hold = 1'b0;
    cyc();
    lit("bp_reg1", rg(1), 32'h11);
    lit("bp_onehot1", we_onehot, 32'h2);
    cyc();
    lit("bp_reg2", rg(2), 32'h22);
    lit("bp_onehot2", we_onehot, 32'h4);
    lit("bp_ready_back", {31'd0, wr_ready}, 32'd1);
    wr_valid = 1'b0;
    cyc();
    lit("bp_reg3", rg(3), 32'h33);
    cyc();
    lit("bp_idle", {31'd0, busy}, 32'd0);

    wr_valid = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF;
    cyc();
    wr_valid = 1'b0;
    cyc();
    lit("x0_slice", rg(0), 32'd0);
    lit("x0_onehot", we_onehot, 32'd0);
`ifdef RF_X0_WRITE_FLAG_EN
    lit("x0_flag", {31'd0, x0_wr_flag}, 32'd1);
`endif

    wr_valid = 1'b1; wr_addr = 5'd7; wr_data = 32'd1;
    cyc();
    wr_data = 32'd2;
    cyc();
    lit("same_rd_first", rg(7), 32'd1);
    lit("same_rd_onehot", we_onehot, 32'h80);
    wr_valid = 1'b0;
    cyc();
    lit("same_rd_final", rg(7), 32'd2);

    rst = 1'b1;
    cyc();
    rst = 1'b0;
    wr_hold = 1'b1;
    wr_valid = 1'b1; wr_addr = 5'd9; wr_data = 32'hAA;
    cyc();
    wr_addr = 5'd10; wr_data = 32'hBB;
    cyc();
    lit("mid_full", {31'd0, wr_ready}, 32'd0);
    wr_valid = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0; wr_hold = 1'b0;
    cyc(); cyc();
    lit("mid_busy", {31'd0, busy}, 32'd0);
    lit("mid_reg9", rg(9), 32'd0);
    lit("mid_reg10", rg(10), 32'd0);
    lit("mid_onehot", we_onehot, 32'd0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
